// File: rtl/ws2812_strand_driver.sv
// WS2812 strand driver: walks LED indices, fetches each GRB colour from a pattern block
// and serialises it onto the single-wire data line, closing every frame with a latch gap.
module ws2812_strand_driver #(
    parameter int CLOCK_SPEED = 100_000_000,
    parameter int NUM_LEDS    = 20,
    parameter int COLOR_WIDTH = 8,
    parameter int T0H_NS      = 400,
    parameter int T0L_NS      = 850,
    parameter int T1H_NS      = 800,
    parameter int T1L_NS      = 450,
    parameter int RESET_US    = 80
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic                        enable_in,
    output logic [$clog2(NUM_LEDS)-1:0] next_led_request,
    output logic                        request_valid,
    input  logic [COLOR_WIDTH-1:0]      green_in,
    input  logic [COLOR_WIDTH-1:0]      red_in,
    input  logic [COLOR_WIDTH-1:0]      blue_in,
    input  logic                        color_ready,
    output logic                        strand_out,
    output logic                        frame_done,
    output logic                        underrun
);

    localparam int CYC_PER_US = CLOCK_SPEED / 1_000_000;
    localparam int T0H_CYC    = CYC_PER_US * T0H_NS / 1000;
    localparam int T0L_CYC    = CYC_PER_US * T0L_NS / 1000;
    localparam int T1H_CYC    = CYC_PER_US * T1H_NS / 1000;
    localparam int T1L_CYC    = CYC_PER_US * T1L_NS / 1000;
    localparam int RESET_CYC  = CYC_PER_US * RESET_US;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = max2(max2(RESET_CYC, T0H_CYC), max2(max2(T0L_CYC, T1H_CYC), T1L_CYC));
    localparam int TMR_W   = $clog2(MAX_CYC + 1);
    localparam int BITS    = 3 * COLOR_WIDTH;
    localparam int BIT_W   = $clog2(BITS);
    localparam int IDX_W   = $clog2(NUM_LEDS);

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BITS - 1);
    localparam logic [IDX_W-1:0] LAST_LED = IDX_W'(NUM_LEDS - 1);

    function automatic logic [TMR_W-1:0] hi_load(input logic bit_val);
        return bit_val ? TMR_W'(T1H_CYC - 1) : TMR_W'(T0H_CYC - 1);
    endfunction

    function automatic logic [TMR_W-1:0] lo_load(input logic bit_val);
        return bit_val ? TMR_W'(T1L_CYC - 1) : TMR_W'(T0L_CYC - 1);
    endfunction

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH0, S_SEND_HI, S_SEND_LO, S_STALL, S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [BITS-1:0]   shift_q, shift_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [IDX_W-1:0]  led_q, led_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              req_vld_q, req_vld_d;
    logic              ignore_q, ignore_d;
    logic              pending_q, pending_d;
    logic [BITS-1:0]   buf_q, buf_d;
    logic              buf_vld_q, buf_vld_d;
    logic              underrun_q, underrun_d;
    logic              strand_q, strand_d;
    logic              frame_done_q, frame_done_d;

    logic              latch_now;
    logic              load_led;
    logic [BITS-1:0]   color_in;
    logic [BITS-1:0]   next_color;
    logic [IDX_W-1:0]  led_next;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        shift_d    = shift_q;
        bit_d      = bit_q;
        led_d      = led_q;
        idx_d      = idx_q;
        req_vld_d  = req_vld_q;
        ignore_d   = 1'b0;
        pending_d  = pending_q;
        buf_d      = buf_q;
        buf_vld_d  = buf_vld_q;
        underrun_d = underrun_q;
        load_led   = 1'b0;

        // The pattern block answers one cycle late, so the cycle after a request change is skipped.
        latch_now  = pending_q && !ignore_q && color_ready;
        color_in   = {green_in, red_in, blue_in};
        next_color = latch_now ? color_in : buf_q;
        led_next   = led_q + 1'b1;

        if (latch_now) begin
            pending_d = 1'b0;
            buf_d     = color_in;
            buf_vld_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (enable_in) begin
                    idx_d     = '0;
                    req_vld_d = 1'b1;
                    ignore_d  = 1'b1;
                    pending_d = 1'b1;
                    led_d     = '0;
                    state_d   = S_FETCH0;
                end
            end
            S_FETCH0: begin
                if (latch_now) begin
                    buf_vld_d = 1'b0;
                    shift_d   = color_in;
                    timer_d   = hi_load(color_in[BITS-1]);
                    bit_d     = '0;
                    led_d     = '0;
                    idx_d     = IDX_W'(1);
                    ignore_d  = 1'b1;
                    pending_d = 1'b1;
                    state_d   = S_SEND_HI;
                end
            end
            S_SEND_HI: begin
                if (timer_q == '0) begin
                    timer_d = lo_load(shift_q[BITS-1]);
                    state_d = S_SEND_LO;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_SEND_LO: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else if (bit_q != LAST_BIT) begin
                    shift_d = shift_q << 1;
                    bit_d   = bit_q + 1'b1;
                    timer_d = hi_load(shift_q[BITS-2]);
                    state_d = S_SEND_HI;
                end else if (led_q == LAST_LED) begin
                    // Moving the index off the last LED tells the pattern block the frame was shown.
                    idx_d     = '0;
                    req_vld_d = 1'b0;
                    pending_d = 1'b0;
                    timer_d   = TMR_W'(RESET_CYC - 1);
                    state_d   = S_GAP;
                end else if (buf_vld_q || latch_now) begin
                    load_led = 1'b1;
                end else begin
                    underrun_d = 1'b1;
                    state_d    = S_STALL;
                end
            end
            S_STALL: begin
                if (latch_now) begin
                    load_led = 1'b1;
                end
            end
            S_GAP: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else if (enable_in) begin
                    idx_d     = '0;
                    req_vld_d = 1'b1;
                    ignore_d  = 1'b1;
                    pending_d = 1'b1;
                    led_d     = '0;
                    state_d   = S_FETCH0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Next LED starts immediately; its successor is requested unless it is the last one.
        if (load_led) begin
            shift_d   = next_color;
            buf_vld_d = 1'b0;
            timer_d   = hi_load(next_color[BITS-1]);
            bit_d     = '0;
            led_d     = led_next;
            state_d   = S_SEND_HI;
            if (led_next != LAST_LED) begin
                idx_d     = led_next + 1'b1;
                ignore_d  = 1'b1;
                pending_d = 1'b1;
            end
        end

        strand_d     = (state_d == S_SEND_HI);
        frame_done_d = (state_d == S_GAP) && (timer_d == '0);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            shift_q      <= '0;
            bit_q        <= '0;
            led_q        <= '0;
            idx_q        <= '0;
            req_vld_q    <= 1'b0;
            ignore_q     <= 1'b0;
            pending_q    <= 1'b0;
            buf_q        <= '0;
            buf_vld_q    <= 1'b0;
            underrun_q   <= 1'b0;
            strand_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            shift_q      <= shift_d;
            bit_q        <= bit_d;
            led_q        <= led_d;
            idx_q        <= idx_d;
            req_vld_q    <= req_vld_d;
            ignore_q     <= ignore_d;
            pending_q    <= pending_d;
            buf_q        <= buf_d;
            buf_vld_q    <= buf_vld_d;
            underrun_q   <= underrun_d;
            strand_q     <= strand_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign next_led_request = idx_q;
    assign request_valid    = req_vld_q;
    assign strand_out       = strand_q;
    assign frame_done       = frame_done_q;
    assign underrun         = underrun_q;

endmodule

// File: tb/tb_ws2812_strand_driver.sv
// Bench for ws2812_strand_driver: registered pattern-block model plus a scoreboard of
// expected bit pulse widths, frame gaps and request-index changes.
module tb_ws2812_strand_driver;

    localparam int N_LEDS    = 3;
    localparam int RESET_CYC = 100;
    localparam int T0H       = 40;
    localparam int T0L       = 85;
    localparam int T1H       = 80;
    localparam int T1L       = 45;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [1:0] next_led_request;
    logic       request_valid;
    logic [7:0] green, red, blue;
    logic       color_ready;
    logic       strand_out;
    logic       frame_done;
    logic       underrun;

    logic        block_led1;
    logic [23:0] colors [N_LEDS];

    typedef struct {
        int hi;
        int lo;
        bit exact;
        bit last;
    } bit_exp_t;

    bit_exp_t sb[$];
    int       idx_q[$];
    int       n_checks = 0;
    int       n_fail   = 0;
    int       done_cnt = 0;

    logic mon_lvl;
    int   mon_run;
    int   mon_hi;
    int   mon_prev_idx;

    always #5 clk = ~clk;

    ws2812_strand_driver #(
        .CLOCK_SPEED(100_000_000),
        .NUM_LEDS   (N_LEDS),
        .COLOR_WIDTH(8),
        .T0H_NS     (400),
        .T0L_NS     (850),
        .T1H_NS     (800),
        .T1L_NS     (450),
        .RESET_US   (1)
    ) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .enable_in       (enable),
        .next_led_request(next_led_request),
        .request_valid   (request_valid),
        .green_in        (green),
        .red_in          (red),
        .blue_in         (blue),
        .color_ready     (color_ready),
        .strand_out      (strand_out),
        .frame_done      (frame_done),
        .underrun        (underrun)
    );

    // Pattern block: answers the current request one cycle later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_ready <= 1'b0;
            {green, red, blue} <= 24'h0;
        end else begin
            color_ready <= request_valid && !(block_led1 && next_led_request == 2'd1);
            if (next_led_request < 2'd3)
                {green, red, blue} <= colors[next_led_request];
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic push_frame(input bit stall_led1);
        bit_exp_t    e;
        logic [23:0] c;
        for (int led = 0; led < N_LEDS; led++) begin
            c = colors[led];
            for (int b = 23; b >= 0; b--) begin
                e.hi    = c[b] ? T1H : T0H;
                e.lo    = c[b] ? T1L : T0L;
                e.exact = 1'b1;
                e.last  = 1'b0;
                if (led == N_LEDS - 1 && b == 0) begin
                    e.last = 1'b1;
                    e.lo   = e.lo + RESET_CYC;
                end
                if (stall_led1 && led == 0 && b == 0) begin
                    e.exact = 1'b0;
                    e.lo    = 500;
                end
                sb.push_back(e);
            end
        end
        idx_q.push_back(1);
        idx_q.push_back(2);
        idx_q.push_back(0);
    endtask

    task automatic finish_bit(input int hi, input int lo);
        bit_exp_t e;
        if (sb.size() == 0) begin
            check_val("bit_unexpected", hi, 0);
            return;
        end
        e = sb.pop_front();
        check_val("bit_hi", hi, e.hi);
        check_val("bit_not_last", int'(e.last), 0);
        if (e.exact) check_val("bit_lo", lo, e.lo);
        else         check_val("bit_lo_min", int'(lo >= e.lo), 1);
    endtask

    task automatic finish_frame(input int hi, input int lo);
        bit_exp_t e;
        if (sb.size() == 0) begin
            check_val("frame_done_unexpected", done_cnt, 0);
            return;
        end
        e = sb.pop_front();
        check_val("last_bit_hi", hi, e.hi);
        check_val("frame_end", int'(e.last), 1);
        check_val("gap_len", lo, e.lo);
    endtask

    // Decodes strand_out into pulse widths and tracks request-index changes.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_lvl      = 1'b0;
            mon_run      = 0;
            mon_hi       = 0;
            mon_prev_idx = 0;
        end else begin
            if (strand_out == mon_lvl) begin
                mon_run++;
            end else begin
                if (strand_out) begin
                    if (mon_hi != 0) finish_bit(mon_hi, mon_run);
                    mon_hi = 0;
                end else begin
                    mon_hi = mon_run;
                end
                mon_lvl = strand_out;
                mon_run = 1;
            end
            if (frame_done) begin
                done_cnt++;
                finish_frame(mon_hi, mon_run);
                mon_hi = 0;
            end
            if (int'(next_led_request) != mon_prev_idx) begin
                if (idx_q.size() == 0) check_val("idx_unexpected", int'(next_led_request), mon_prev_idx);
                else                   check_val("idx_seq", int'(next_led_request), idx_q.pop_front());
                mon_prev_idx = int'(next_led_request);
            end
        end
    end

    task automatic wait_done(input int target, input int budget, input string tag);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, done_cnt, target);
    endtask

    task automatic count_highs(input int cycles, output int highs);
        highs = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (strand_out) highs++;
        end
    endtask

    initial begin
        int n;
        int highs;
        colors[0]  = 24'h800000;
        colors[1]  = 24'h5A3C81;
        colors[2]  = 24'h00FF0F;
        rst_n      = 1'b0;
        enable     = 1'b0;
        block_led1 = 1'b0;

        repeat (3) @(negedge clk);
        check_val("rst_strand", int'(strand_out), 0);
        check_val("rst_req_valid", int'(request_valid), 0);
        check_val("rst_idx", int'(next_led_request), 0);
        check_val("rst_frame_done", int'(frame_done), 0);
        check_val("rst_underrun", int'(underrun), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_val("idle_strand", int'(strand_out), 0);
        check_val("idle_req_valid", int'(request_valid), 0);

        // Two back-to-back frames, enable dropped in the middle of the second one's LED1.
        push_frame(1'b0);
        push_frame(1'b0);
        enable = 1'b1;
        wait_done(1, 12000, "frame1_done");
        n = 0;
        while (next_led_request != 2'd2 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check_val("frame2_led1_reached", int'(next_led_request), 2);
        repeat (1000) @(negedge clk);
        enable = 1'b0;
        wait_done(2, 12000, "frame2_done");
        count_highs(300, highs);
        check_val("idle_after_drop_highs", highs, 0);
        check_val("idle_after_drop_req_valid", int'(request_valid), 0);
        check_val("sb_drained", sb.size(), 0);
        check_val("idx_drained", idx_q.size(), 0);
        check_val("underrun_clear", int'(underrun), 0);

        // LED1 colour withheld: strand must idle low until it arrives.
        block_led1 = 1'b1;
        push_frame(1'b1);
        enable = 1'b1;
        n = 0;
        while (!underrun && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_val("underrun_set", int'(underrun), 1);
        enable = 1'b0;
        count_highs(500, highs);
        check_val("stall_low_highs", highs, 0);
        check_val("underrun_sticky", int'(underrun), 1);
        block_led1 = 1'b0;
        n = 0;
        while (sb.size() > 20 && n < 8000) begin
            @(negedge clk);
            n++;
        end
        check_val("led1_resumed", int'(sb.size() <= 20), 1);

        // Asynchronous reset in the middle of a high phase.
        n = 0;
        while (!strand_out && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_val("strand_high_before_reset", int'(strand_out), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_strand", int'(strand_out), 0);
        check_val("async_rst_req_valid", int'(request_valid), 0);
        check_val("async_rst_underrun", int'(underrun), 0);
        check_val("async_rst_idx", int'(next_led_request), 0);
        sb.delete();
        idx_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        count_highs(300, highs);
        check_val("post_reset_idle_highs", highs, 0);
        check_val("post_reset_req_valid", int'(request_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
